scr1_ahb_imem_dmem_arb: RTL

- Two-master to one-slave AHB-Lite arbiter.
- Merges the core's instruction-fetch AHB master (imem, read-only) and data AHB master (dmem, read/write) onto one shared AHB-Lite slave port, such as a unified TB memory or an SoC fabric port.
- Arbitrates address phases, tracks data-phase ownership, stalls the losing master through its hready, and routes response and data back to the owner.
- No transfer buffering: pure address-phase muxing plus ownership state.

---
 rtl/scr1_ahb_imem_dmem_arb.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/scr1_ahb_imem_dmem_arb.sv
// Two-master (imem fetch, dmem load/store) to one-slave AHB-Lite arbiter.
// The address path is purely combinational. Registered state tracks data-phase ownership and arbitration history.
module scr1_ahb_imem_dmem_arb #(
  parameter int AHB_W           = 32,
  parameter int ARB_MODE        = 0,
  parameter int DMEM_MAX_CONSEC = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic [1:0]       imem_htrans,
  input  logic [2:0]       imem_hsize,
  input  logic [2:0]       imem_hburst,
  input  logic [3:0]       imem_hprot,
  input  logic [AHB_W-1:0] imem_haddr,
  output logic             imem_hready,
  output logic [AHB_W-1:0] imem_hrdata,
  output logic             imem_hresp,

  input  logic [1:0]       dmem_htrans,
  input  logic [2:0]       dmem_hsize,
  input  logic [2:0]       dmem_hburst,
  input  logic [3:0]       dmem_hprot,
  input  logic [AHB_W-1:0] dmem_haddr,
  input  logic             dmem_hwrite,
  input  logic [AHB_W-1:0] dmem_hwdata,
  output logic             dmem_hready,
  output logic [AHB_W-1:0] dmem_hrdata,
  output logic             dmem_hresp,

  output logic [1:0]       s_htrans,
  output logic [2:0]       s_hsize,
  output logic [2:0]       s_hburst,
  output logic [3:0]       s_hprot,
  output logic [AHB_W-1:0] s_haddr,
  output logic             s_hwrite,
  output logic [AHB_W-1:0] s_hwdata,
  input  logic             s_hready,
  input  logic [AHB_W-1:0] s_hrdata,
  input  logic             s_hresp
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_e;

  localparam logic [3:0] MAX_CONSEC = 4'(DMEM_MAX_CONSEC);
  localparam logic [3:0] CNT_SAT    = 4'hF;

  owner_e     dph_owner_reg,  dph_owner_next;
  owner_e     last_grant_reg, last_grant_next;
  logic [3:0] consec_cnt_reg, consec_cnt_next;

  logic req_i;
  logic req_d;
  logic grant_i;
  logic grant_d;

  // NONSEQ and SEQ both carry htrans[1]; IDLE and BUSY never request the bus.
  assign req_i = imem_htrans[1];
  assign req_d = dmem_htrans[1];

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (req_i && req_d) begin
      if (ARB_MODE == 1) begin
        // dmem has priority, but imem is forced through after a run of dmem wins
        if (consec_cnt_reg == MAX_CONSEC) grant_i = 1'b1;
        else                              grant_d = 1'b1;
      end else begin
        if (last_grant_reg == OWN_DMEM) grant_i = 1'b1;
        else                            grant_d = 1'b1;
      end
    end else begin
      grant_i = req_i;
      grant_d = req_d;
    end
  end

  // State only advances when the slave accepts the current address phase.
  always_comb begin
    dph_owner_next  = dph_owner_reg;
    last_grant_next = last_grant_reg;
    consec_cnt_next = consec_cnt_reg;
    if (s_hready) begin
      if (grant_i) begin
        dph_owner_next  = OWN_IMEM;
        last_grant_next = OWN_IMEM;
      end else if (grant_d) begin
        dph_owner_next  = OWN_DMEM;
        last_grant_next = OWN_DMEM;
      end else begin
        dph_owner_next  = OWN_NONE;
      end

      if (grant_i || !req_i) begin
        consec_cnt_next = 4'd0;
      end else if (grant_d && (consec_cnt_reg != CNT_SAT)) begin
        consec_cnt_next = consec_cnt_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dph_owner_reg  <= OWN_NONE;
      last_grant_reg <= OWN_IMEM;
      consec_cnt_reg <= 4'd0;
    end else begin
      dph_owner_reg  <= dph_owner_next;
      last_grant_reg <= last_grant_next;
      consec_cnt_reg <= consec_cnt_next;
    end
  end

  always_comb begin
    s_htrans = 2'b00;
    s_hsize  = 3'd0;
    s_hburst = 3'd0;
    s_hprot  = 4'd0;
    s_haddr  = '0;
    s_hwrite = 1'b0;
    if (grant_d) begin
      s_htrans = dmem_htrans;
      s_hsize  = dmem_hsize;
      s_hburst = dmem_hburst;
      s_hprot  = dmem_hprot;
      s_haddr  = dmem_haddr;
      s_hwrite = dmem_hwrite;
    end else if (grant_i) begin
      s_htrans = imem_htrans;
      s_hsize  = imem_hsize;
      s_hburst = imem_hburst;
      s_hprot  = imem_hprot;
      s_haddr  = imem_haddr;
    end
  end

  assign s_hwdata    = (dph_owner_reg == OWN_DMEM) ? dmem_hwdata : '0;
  assign imem_hrdata = s_hrdata;
  assign dmem_hrdata = s_hrdata;
  assign imem_hresp  = (dph_owner_reg == OWN_IMEM) ? s_hresp : 1'b0;
  assign dmem_hresp  = (dph_owner_reg == OWN_DMEM) ? s_hresp : 1'b0;

  // A master stalls while its own data phase waits, or while its pending address has not been accepted.
  assign imem_hready = ((dph_owner_reg == OWN_IMEM) ? s_hready : 1'b1)
                     & (~req_i | (grant_i & s_hready));
  assign dmem_hready = ((dph_owner_reg == OWN_DMEM) ? s_hready : 1'b1)
                     & (~req_d | (grant_d & s_hready));

endmodule
